// File: rtl/pipeline_hazard_controller.sv
// Stall/flush controller for the two-stage (fd -> em) 10-bit pipeline.
// Covers load-use hazards, multi-cycle memory waits and taken branches,
// which the forwarding path cannot resolve on its own.
// Outputs are Mealy (state + current inputs); state, counters and flags are registered.
module pipeline_hazard_controller #(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int MAX_MEM_WAIT      = 8,
    parameter int STALL_CNT_WIDTH   = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       enable,
    input  logic [2:0]                 op_code_fd,
    input  logic [2:0]                 reg_source_1_addr_fd,
    input  logic [1:0]                 reg_source_2_addr_fd,
    input  logic                       alu_source_1_select,
    input  logic [1:0]                 alu_source_2_select,
    input  logic [2:0]                 reg_dest_addr_em,
    input  logic                       reg_write_em,
    input  logic                       mem_read_em,
    input  logic                       mem_busy_em,
    input  logic                       branch_taken_em,
    output logic                       pc_write_enable,
    output logic                       fd_pipe_write_enable,
    output logic                       em_bubble,
    output logic                       fd_flush,
    output logic                       forward_enable,
    output logic                       mem_timeout,
    output logic [STALL_CNT_WIDTH-1:0] stall_count,
    output logic [1:0]                 hazard_state
);

    localparam logic [1:0] RUN        = 2'b00;
    localparam logic [1:0] STALL_LOAD = 2'b01;
    localparam logic [1:0] WAIT_MEM   = 2'b10;

    localparam logic [2:0] OP_STORE = 3'b101;

    // Last value of the load counter while in STALL_LOAD; the detection cycle
    // in RUN is the first stall cycle, so STALL_LOAD lasts LOAD_STALL_CYCLES-1.
    localparam int         LOAD_LAST_I = (LOAD_STALL_CYCLES > 2) ? LOAD_STALL_CYCLES - 2 : 0;
    localparam logic [2:0] LOAD_LAST   = 3'(LOAD_LAST_I);
    localparam logic [7:0] WAIT_MAX    = 8'(MAX_MEM_WAIT);

    logic [1:0] state, state_n;
    logic [2:0] load_cnt, load_cnt_n;
    logic [7:0] wait_cnt, wait_cnt_n;
    logic       timeout_set;
    logic       hz;
    logic       eval_run;
    logic       wait_expired;

    // Load-use hazard: the em load targets a register the fd instruction reads.
    always_comb begin
        hz = mem_read_em && reg_write_em && (reg_dest_addr_em != 3'd0) &&
             (((reg_dest_addr_em == reg_source_1_addr_fd) && !alu_source_1_select) ||
              ((reg_dest_addr_em == {1'b0, reg_source_2_addr_fd}) && (alu_source_2_select == 2'b00)) ||
              ((op_code_fd == OP_STORE) && (reg_dest_addr_em == {1'b0, reg_source_2_addr_fd})));
    end

    // RUN and a completed memory wait share the same priority evaluation.
    always_comb begin
        eval_run     = (state == RUN) || ((state == WAIT_MEM) && !mem_busy_em);
        wait_expired = (state == WAIT_MEM) && mem_busy_em && (wait_cnt >= WAIT_MAX);
    end

    // State, counter and flag registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= RUN;
            load_cnt    <= 3'd0;
            wait_cnt    <= 8'd0;
            mem_timeout <= 1'b0;
        end else begin
            state    <= state_n;
            load_cnt <= load_cnt_n;
            wait_cnt <= wait_cnt_n;
            if (timeout_set) begin
                mem_timeout <= 1'b1;
            end
        end
    end

    // Next-state and counter update logic.
    always_comb begin
        state_n     = state;
        load_cnt_n  = load_cnt;
        wait_cnt_n  = wait_cnt;
        timeout_set = 1'b0;
        if (!enable) begin
            state_n = RUN;
        end else if (eval_run) begin
            if (mem_busy_em) begin
                state_n    = WAIT_MEM;
                wait_cnt_n = 8'd1;
            end else if (branch_taken_em) begin
                state_n = RUN;
            end else if (hz) begin
                state_n    = (LOAD_STALL_CYCLES > 1) ? STALL_LOAD : RUN;
                load_cnt_n = 3'd0;
            end else begin
                state_n = RUN;
            end
        end else begin
            case (state)
                STALL_LOAD: begin
                    if (load_cnt >= LOAD_LAST) begin
                        state_n    = RUN;
                        load_cnt_n = 3'd0;
                    end else begin
                        load_cnt_n = load_cnt + 3'd1;
                    end
                end
                WAIT_MEM: begin
                    if (wait_expired) begin
                        timeout_set = 1'b1;
                        state_n     = RUN;
                        wait_cnt_n  = 8'd0;
                    end else begin
                        wait_cnt_n = wait_cnt + 8'd1;
                    end
                end
                default: state_n = RUN;
            endcase
        end
    end

    // Mealy output decode; everything is held low while reset is asserted.
    always_comb begin
        pc_write_enable      = 1'b1;
        fd_pipe_write_enable = 1'b1;
        em_bubble            = 1'b0;
        fd_flush             = 1'b0;
        forward_enable       = 1'b1;
        if (!reset_n) begin
            pc_write_enable      = 1'b0;
            fd_pipe_write_enable = 1'b0;
            forward_enable       = 1'b0;
        end else if (!enable) begin
            fd_flush       = branch_taken_em;
            forward_enable = 1'b0;
        end else if (eval_run) begin
            if (mem_busy_em) begin
                pc_write_enable      = 1'b0;
                fd_pipe_write_enable = 1'b0;
                forward_enable       = 1'b0;
            end else if (branch_taken_em) begin
                fd_flush = 1'b1;
            end else if (hz) begin
                pc_write_enable = 1'b0;
                em_bubble       = 1'b1;
                forward_enable  = 1'b0;
            end
        end else if (state == STALL_LOAD) begin
            pc_write_enable = 1'b0;
            em_bubble       = 1'b1;
            forward_enable  = 1'b0;
        end else if ((state == WAIT_MEM) && !wait_expired) begin
            pc_write_enable      = 1'b0;
            fd_pipe_write_enable = 1'b0;
            forward_enable       = 1'b0;
        end
    end

    // Saturating count of cycles in which the PC was held.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_count <= '0;
        end else if (!pc_write_enable && (stall_count != '1)) begin
            stall_count <= stall_count + 1'b1;
        end
    end

    assign hazard_state = state;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench: dut1 uses LOAD_STALL_CYCLES=1, dut3 uses 3; both share inputs.
module tb_pipeline_hazard_controller;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       enable;
    logic [2:0] op_code_fd;
    logic [2:0] src1;
    logic [1:0] src2;
    logic       sel1;
    logic [1:0] sel2;
    logic [2:0] dest;
    logic       reg_write_em;
    logic       mem_read_em;
    logic       mem_busy_em;
    logic       branch_taken_em;

    logic        pc1, fdwe1, bub1, fl1, fwd1, to1;
    logic [15:0] sc1;
    logic [1:0]  st1;
    logic        pc3, fdwe3, bub3, fl3, fwd3, to3;
    logic [15:0] sc3;
    logic [1:0]  st3;

    wire [4:0] o1 = {pc1, fdwe1, bub1, fl1, fwd1};
    wire [4:0] o3 = {pc3, fdwe3, bub3, fl3, fwd3};

    // {pc_we, fd_we, bubble, flush, fwd}
    localparam logic [4:0] NEUTRAL = 5'b11001;
    localparam logic [4:0] STALL   = 5'b01100;
    localparam logic [4:0] FREEZE  = 5'b00000;
    localparam logic [4:0] BRANCH  = 5'b11011;
    localparam logic [4:0] DIS     = 5'b11000;
    localparam logic [4:0] DIS_BR  = 5'b11010;
    localparam logic [4:0] IN_RST  = 5'b00000;

    int checks   = 0;
    int failures = 0;
    int exp_sc1  = 0;
    int exp_sc3  = 0;

    pipeline_hazard_controller #(.LOAD_STALL_CYCLES(1), .MAX_MEM_WAIT(8), .STALL_CNT_WIDTH(16)) dut1 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .op_code_fd(op_code_fd),
        .reg_source_1_addr_fd(src1), .reg_source_2_addr_fd(src2),
        .alu_source_1_select(sel1), .alu_source_2_select(sel2),
        .reg_dest_addr_em(dest), .reg_write_em(reg_write_em), .mem_read_em(mem_read_em),
        .mem_busy_em(mem_busy_em), .branch_taken_em(branch_taken_em),
        .pc_write_enable(pc1), .fd_pipe_write_enable(fdwe1), .em_bubble(bub1),
        .fd_flush(fl1), .forward_enable(fwd1), .mem_timeout(to1),
        .stall_count(sc1), .hazard_state(st1)
    );

    pipeline_hazard_controller #(.LOAD_STALL_CYCLES(3), .MAX_MEM_WAIT(8), .STALL_CNT_WIDTH(16)) dut3 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .op_code_fd(op_code_fd),
        .reg_source_1_addr_fd(src1), .reg_source_2_addr_fd(src2),
        .alu_source_1_select(sel1), .alu_source_2_select(sel2),
        .reg_dest_addr_em(dest), .reg_write_em(reg_write_em), .mem_read_em(mem_read_em),
        .mem_busy_em(mem_busy_em), .branch_taken_em(branch_taken_em),
        .pc_write_enable(pc3), .fd_pipe_write_enable(fdwe3), .em_bubble(bub3),
        .fd_flush(fl3), .forward_enable(fwd3), .mem_timeout(to3),
        .stall_count(sc3), .hazard_state(st3)
    );

    // Clock: 10 time-unit period.
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        enable          = 1'b1;
        op_code_fd      = 3'b000;
        src1            = 3'd0;
        src2            = 2'd0;
        sel1            = 1'b1;
        sel2            = 2'b01;
        dest            = 3'd0;
        reg_write_em    = 1'b0;
        mem_read_em     = 1'b0;
        mem_busy_em     = 1'b0;
        branch_taken_em = 1'b0;
    endtask

    task automatic drive_load_hz();
        mem_read_em  = 1'b1;
        reg_write_em = 1'b1;
        dest         = 3'b011;
        src2         = 2'b11;
        sel2         = 2'b00;
        sel1         = 1'b1;
        src1         = 3'd0;
    endtask

    task automatic test_reset();
        drive_idle();
        reset_n = 1'b0;
        repeat (2) tick();
        checks++;
        if (o1 !== IN_RST) begin failures++; $display("FAIL reset_outs got %b exp %b", o1, IN_RST); end
        checks++;
        if (st1 !== 2'b00 || sc1 !== 16'd0 || to1 !== 1'b0) begin
            failures++; $display("FAIL reset_regs got st=%b sc=%0d to=%b exp 00/0/0", st1, sc1, to1);
        end
        reset_n = 1'b1;
        #1;
        checks++;
        if (o1 !== NEUTRAL) begin failures++; $display("FAIL reset_release got %b exp %b", o1, NEUTRAL); end
        tick();
    endtask

    task automatic test_load_use();
        drive_load_hz();
        #1;
        checks++;
        if (o1 !== STALL) begin failures++; $display("FAIL load_use_stall got %b exp %b", o1, STALL); end
        tick();
        exp_sc1 += 1;
        exp_sc3 += 3;
        drive_idle();
        #1;
        checks++;
        if (o1 !== NEUTRAL || st1 !== 2'b00) begin
            failures++; $display("FAIL load_use_after got %b st=%b exp %b st=00", o1, st1, NEUTRAL);
        end
        tick();
        checks++;
        if (sc1 !== 16'(exp_sc1)) begin failures++; $display("FAIL load_use_count got %0d exp %0d", sc1, exp_sc1); end
        tick();
        tick();
        drive_load_hz();
        dest = 3'b000;
        src2 = 2'b00;
        #1;
        checks++;
        if (o1 !== NEUTRAL || o3 !== NEUTRAL) begin
            failures++; $display("FAIL load_dest0 got %b/%b exp %b", o1, o3, NEUTRAL);
        end
        tick();
        drive_idle();
        checks++;
        if (sc1 !== 16'(exp_sc1) || sc3 !== 16'(exp_sc3)) begin
            failures++; $display("FAIL load_dest0_count got %0d/%0d exp %0d/%0d", sc1, sc3, exp_sc1, exp_sc3);
        end
    endtask

    task automatic test_store_stall3();
        logic [1:0] exp_st [3];
        exp_st[0] = 2'b01;
        exp_st[1] = 2'b01;
        exp_st[2] = 2'b00;
        mem_read_em  = 1'b1;
        reg_write_em = 1'b1;
        op_code_fd   = 3'b101;
        dest         = 3'b010;
        src2         = 2'b10;
        sel2         = 2'b01;
        sel1         = 1'b1;
        src1         = 3'd5;
        #1;
        checks++;
        if (o3 !== STALL || st3 !== 2'b00) begin
            failures++; $display("FAIL store_detect got %b st=%b exp %b st=00", o3, st3, STALL);
        end
        tick();
        drive_idle();
        exp_sc1 += 1;
        exp_sc3 += 3;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (st3 !== exp_st[i] || o3 !== ((i < 2) ? STALL : NEUTRAL)) begin
                failures++; $display("FAIL store_seq%0d got st=%b o=%b exp st=%b", i, st3, o3, exp_st[i]);
            end
            tick();
        end
        checks++;
        if (sc3 !== 16'(exp_sc3)) begin failures++; $display("FAIL store_count got %0d exp %0d", sc3, exp_sc3); end
    endtask

    task automatic test_mem_wait();
        mem_busy_em = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (o1 !== FREEZE) begin failures++; $display("FAIL mem_freeze%0d got %b exp %b", i, o1, FREEZE); end
            tick();
            checks++;
            if (st1 !== 2'b10) begin failures++; $display("FAIL mem_state%0d got %b exp 10", i, st1); end
        end
        mem_busy_em = 1'b0;
        #1;
        checks++;
        if (o1 !== NEUTRAL) begin failures++; $display("FAIL mem_done got %b exp %b", o1, NEUTRAL); end
        tick();
        exp_sc1 += 4;
        exp_sc3 += 4;
        checks++;
        if (st1 !== 2'b00 || sc1 !== 16'(exp_sc1) || to1 !== 1'b0) begin
            failures++; $display("FAIL mem_after got st=%b sc=%0d to=%b exp 00/%0d/0", st1, sc1, to1, exp_sc1);
        end
        mem_busy_em = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            checks++;
            if (o1 !== FREEZE) begin failures++; $display("FAIL tmo_freeze%0d got %b exp %b", i, o1, FREEZE); end
            tick();
        end
        exp_sc1 += 8;
        exp_sc3 += 8;
        checks++;
        if (to1 !== 1'b0 || st1 !== 2'b10) begin
            failures++; $display("FAIL tmo_early got to=%b st=%b exp 0/10", to1, st1);
        end
        #1;
        checks++;
        if (o1 !== NEUTRAL) begin failures++; $display("FAIL tmo_release got %b exp %b", o1, NEUTRAL); end
        tick();
        mem_busy_em = 1'b0;
        checks++;
        if (to1 !== 1'b1 || to3 !== 1'b1 || st1 !== 2'b00) begin
            failures++; $display("FAIL tmo_flag got to=%b/%b st=%b exp 1/1/00", to1, to3, st1);
        end
        checks++;
        if (sc1 !== 16'(exp_sc1)) begin failures++; $display("FAIL tmo_count got %0d exp %0d", sc1, exp_sc1); end
    endtask

    task automatic test_simultaneous();
        drive_load_hz();
        mem_busy_em     = 1'b1;
        branch_taken_em = 1'b1;
        #1;
        checks++;
        if (o1 !== FREEZE || o3 !== FREEZE) begin
            failures++; $display("FAIL simul_freeze got %b/%b exp %b", o1, o3, FREEZE);
        end
        tick();
        checks++;
        if (st1 !== 2'b10) begin failures++; $display("FAIL simul_state got %b exp 10", st1); end
        mem_busy_em = 1'b0;
        #1;
        checks++;
        if (o1 !== BRANCH || o3 !== BRANCH) begin
            failures++; $display("FAIL simul_branch got %b/%b exp %b", o1, o3, BRANCH);
        end
        tick();
        drive_idle();
        exp_sc1 += 1;
        exp_sc3 += 1;
        #1;
        checks++;
        if (o1 !== NEUTRAL || st1 !== 2'b00 || sc1 !== 16'(exp_sc1)) begin
            failures++; $display("FAIL simul_after got %b st=%b sc=%0d exp %b 00 %0d", o1, st1, sc1, NEUTRAL, exp_sc1);
        end
    endtask

    task automatic test_disable();
        drive_load_hz();
        enable      = 1'b0;
        mem_busy_em = 1'b1;
        #1;
        checks++;
        if (o1 !== DIS || o3 !== DIS) begin failures++; $display("FAIL dis_outs got %b/%b exp %b", o1, o3, DIS); end
        tick();
        checks++;
        if (st1 !== 2'b00 || st3 !== 2'b00) begin failures++; $display("FAIL dis_state got %b/%b exp 00", st1, st3); end
        branch_taken_em = 1'b1;
        #1;
        checks++;
        if (o1 !== DIS_BR) begin failures++; $display("FAIL dis_branch got %b exp %b", o1, DIS_BR); end
        tick();
        drive_idle();
        checks++;
        if (sc1 !== 16'(exp_sc1) || sc3 !== 16'(exp_sc3) || to1 !== 1'b1) begin
            failures++; $display("FAIL dis_count got %0d/%0d to=%b exp %0d/%0d to=1", sc1, sc3, to1, exp_sc1, exp_sc3);
        end
    endtask

    task automatic test_async_reset();
        mem_busy_em = 1'b1;
        tick();
        tick();
        checks++;
        if (st1 !== 2'b10) begin failures++; $display("FAIL areset_pre got %b exp 10", st1); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (st1 !== 2'b00 || sc1 !== 16'd0 || to1 !== 1'b0 || o1 !== IN_RST) begin
            failures++; $display("FAIL areset_now got st=%b sc=%0d to=%b o=%b exp 00/0/0/%b", st1, sc1, to1, o1, IN_RST);
        end
        tick();
        drive_idle();
        reset_n = 1'b1;
        #1;
        checks++;
        if (o1 !== NEUTRAL) begin failures++; $display("FAIL areset_release got %b exp %b", o1, NEUTRAL); end
        tick();
        checks++;
        if (st1 !== 2'b00 || sc1 !== 16'd0) begin
            failures++; $display("FAIL areset_after got st=%b sc=%0d exp 00/0", st1, sc1);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_store_stall3();
        test_mem_wait();
        test_simultaneous();
        test_disable();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
